mips_cpu_avalon: RTL and testbench

- Multicycle 32-bit MIPS-I subset CPU with a single Avalon-style memory bus, shared by instruction fetch and data access.
- Sits between the system clock/reset and a byte-addressed RAM.
- Exposes `active`, low once the program has jumped to address 0, and `register_v0` ($2) for result checking.
- Branch/jump delay slots are architecturally executed.

---
 rtl/mips_cpu_avalon.sv | 223 ++++++++++++++++++++++
 tb/tb_mips_cpu_avalon.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_avalon.sv
// mips_cpu_avalon: multicycle MIPS-I subset CPU with one Avalon-style bus
// shared by instruction fetch and data access. Delay slots are executed.
// Optional feature macro: MIPS_CPU_BYTE_LS_EN adds LB, LBU and SB.
//
// Bus handshake: a transfer is presented while read or write is high; it
// completes on the first rising edge where waitrequest is low. Until then
// address, byteenable and writedata hold. read and write are never both high.
module mips_cpu_avalon #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20, OP_LW   = 6'h23, OP_LBU  = 6'h24;
    localparam logic [5:0] OP_SB    = 6'h28, OP_SW   = 6'h2B;

    state_t      state, state_nx;
    logic [31:0] pc, npc, ir;
    logic [31:0] regs [32];

    // Instruction fields and operands, all taken from the latched IR.
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] imm_sext, imm_zext, rs_val, rt_val, pc_plus4, link, ea;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign imm      = ir[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'd0, imm};
    assign rs_val   = regs[rs];
    assign rt_val   = regs[rt];
    assign pc_plus4 = pc + 32'd4;
    assign link     = pc + 32'd8;
    assign ea       = rs_val + imm_sext;

    logic        wb_en, taken, is_mem, is_load;
    logic [4:0]  wb_idx;
    logic [31:0] wb_val, target;

    // Decode and ALU: writeback value, control-flow target and memory class.
    always_comb begin
        wb_en   = 1'b0;
        wb_idx  = rt;
        wb_val  = 32'd0;
        taken   = 1'b0;
        target  = 32'd0;
        is_mem  = 1'b0;
        is_load = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                wb_en  = 1'b1;
                wb_idx = rd;
                case (funct)
                    6'h00: wb_val = rt_val << shamt;
                    6'h02: wb_val = rt_val >> shamt;
                    6'h03: wb_val = $unsigned($signed(rt_val) >>> shamt);
                    6'h08: begin wb_en = 1'b0; taken = 1'b1; target = rs_val; end
                    6'h09: begin wb_val = link; taken = 1'b1; target = rs_val; end
                    6'h21: wb_val = rs_val + rt_val;
                    6'h23: wb_val = rs_val - rt_val;
                    6'h24: wb_val = rs_val & rt_val;
                    6'h25: wb_val = rs_val | rt_val;
                    6'h26: wb_val = rs_val ^ rt_val;
                    6'h2A: wb_val = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B: wb_val = {31'd0, rs_val < rt_val};
                    default: wb_en = 1'b0;
                endcase
            end
            OP_J: begin
                taken  = 1'b1;
                target = {pc_plus4[31:28], ir[25:0], 2'b00};
            end
            OP_JAL: begin
                taken  = 1'b1;
                target = {pc_plus4[31:28], ir[25:0], 2'b00};
                wb_en  = 1'b1;
                wb_idx = 5'd31;
                wb_val = link;
            end
            OP_BEQ: begin
                taken  = (rs_val == rt_val);
                target = pc_plus4 + {imm_sext[29:0], 2'b00};
            end
            OP_BNE: begin
                taken  = (rs_val != rt_val);
                target = pc_plus4 + {imm_sext[29:0], 2'b00};
            end
            OP_ADDIU: begin wb_en = 1'b1; wb_val = rs_val + imm_sext; end
            OP_SLTI:  begin wb_en = 1'b1; wb_val = {31'd0, $signed(rs_val) < $signed(imm_sext)}; end
            OP_SLTIU: begin wb_en = 1'b1; wb_val = {31'd0, rs_val < imm_sext}; end
            OP_ANDI:  begin wb_en = 1'b1; wb_val = rs_val & imm_zext; end
            OP_ORI:   begin wb_en = 1'b1; wb_val = rs_val | imm_zext; end
            OP_XORI:  begin wb_en = 1'b1; wb_val = rs_val ^ imm_zext; end
            OP_LUI:   begin wb_en = 1'b1; wb_val = {imm, 16'd0}; end
            OP_LW:    begin is_mem = 1'b1; is_load = 1'b1; end
            OP_SW:    is_mem = 1'b1;
`ifdef MIPS_CPU_BYTE_LS_EN
            OP_LB, OP_LBU: begin is_mem = 1'b1; is_load = 1'b1; end
            OP_SB:         is_mem = 1'b1;
`endif
            default: ;
        endcase
    end

    logic [31:0] load_val, store_data;
    logic [3:0]  mem_be;

`ifdef MIPS_CPU_BYTE_LS_EN
    logic [7:0] byte_sel;

    // Pick the byte lane addressed by the low effective-address bits.
    always_comb begin
        case (ea[1:0])
            2'd0:    byte_sel = readdata[7:0];
            2'd1:    byte_sel = readdata[15:8];
            2'd2:    byte_sel = readdata[23:16];
            default: byte_sel = readdata[31:24];
        endcase
    end
`endif

    // Data-phase lane enables, store data and load result.
    always_comb begin
        load_val   = readdata;
        store_data = rt_val;
        mem_be     = 4'hF;
`ifdef MIPS_CPU_BYTE_LS_EN
        if (opcode == OP_LB || opcode == OP_LBU || opcode == OP_SB) begin
            mem_be     = 4'b0001 << ea[1:0];
            store_data = {4{rt_val[7:0]}};
            load_val   = (opcode == OP_LB) ? {{24{byte_sel[7]}}, byte_sel}
                                           : {24'd0, byte_sel};
        end
`endif
    end

    // Next-state logic; halting is decided on the PC value the step commits.
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: if (!waitrequest) state_nx = S_EXEC;
            S_EXEC:  state_nx = is_mem ? S_MEM : ((npc == 32'd0) ? S_HALT : S_FETCH);
            S_MEM:   if (!waitrequest) state_nx = (pc == 32'd0) ? S_HALT : S_FETCH;
            default: state_nx = S_HALT;
        endcase
    end

    // Bus outputs; reset forces the bus idle so an in-flight transfer is dropped.
    always_comb begin
        address    = 32'd0;
        read       = 1'b0;
        write      = 1'b0;
        byteenable = 4'h0;
        writedata  = 32'd0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    address    = pc;
                    read       = 1'b1;
                    byteenable = 4'hF;
                end
                S_MEM: begin
                    address    = ea & 32'hFFFF_FFFC;
                    byteenable = mem_be;
                    if (is_load) begin
                        read = 1'b1;
                    end else begin
                        write     = 1'b1;
                        writedata = store_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign active      = reset || (state != S_HALT);
    assign register_v0 = regs[2];

    // State, PC pair, IR and register file updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= RESET_VECTOR;
            npc   <= RESET_VECTOR + 32'd4;
            ir    <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            state <= state_nx;
            case (state)
                S_FETCH: if (!waitrequest) ir <= readdata;
                S_EXEC: begin
                    pc  <= npc;
                    npc <= taken ? target : npc + 32'd4;
                    if (wb_en && wb_idx != 5'd0) regs[wb_idx] <= wb_val;
                end
                S_MEM: if (is_load && !waitrequest && rt != 5'd0) regs[rt] <= load_val;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_cpu_avalon.sv
// tb_mips_cpu_avalon: directed and random programs for mips_cpu_avalon,
// checked against an instruction-level reference interpreter.
module tb_mips_cpu_avalon;
    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata;
    logic        active, write, read;
    logic [31:0] register_v0, address, writedata;
    logic [3:0]  byteenable;

    mips_cpu_avalon dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .address(address), .write(write), .read(read), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    // clock / reset block
    always #5 clk = ~clk;

    logic [31:0] prog_mem [256];
    logic [31:0] data_mem [256];
    logic [31:0] ref_mem  [256];
    logic [31:0] m_regs   [32];
    logic [31:0] prog_q [$];
    logic [31:0] exp_q [$];
    int m_cycles;
    int n_checks = 0, n_fail = 0;
    int cyc, stalls, wr_cycles, data_acc, force_wait;
    bit wait_rand;
    logic [3:0]  last_be;
    logic        last_rd;
    logic [31:0] last_addr;
    logic [5:0]  r_fn [10] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
    logic [5:0]  i_op [7]  = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

    // Memory slave read port: program ROM at RV, data RAM at 0..0x3FF.
    always_comb begin
        readdata = 32'd0;
        if (address - RV < 32'd1024) readdata = prog_mem[address[9:2]];
        else if (address < 32'd1024) readdata = data_mem[address[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    task automatic set_wait();
        if (force_wait > 0) begin
            waitrequest = 1'b1;
            force_wait--;
        end else begin
            waitrequest = wait_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    endtask

    // driver: one clock; commits a completed store into data RAM, ends at negedge
    task automatic tick();
        logic        s_wr, s_rd;
        logic [31:0] s_addr, s_wd;
        logic [3:0]  s_be;
        s_wr = write; s_rd = read; s_addr = address; s_wd = writedata; s_be = byteenable;
        check("rw_exclusive", 32'(s_wr & s_rd), 32'd0);
        if (s_addr < 32'd1024 && (s_wr || s_rd)) begin
            data_acc++;
            last_be = s_be; last_rd = s_rd; last_addr = s_addr;
        end
        @(posedge clk);
        if ((s_wr || s_rd) && waitrequest) stalls++;
        if (s_wr && !waitrequest) begin
            wr_cycles++;
            if (s_addr < 32'd1024)
                for (int b = 0; b < 4; b++)
                    if (s_be[b]) data_mem[s_addr[9:2]][8*b +: 8] = s_wd[8*b +: 8];
        end
        @(negedge clk);
        cyc++;
        set_wait();
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) prog_mem[i] = (i < prog_q.size()) ? prog_q[i] : 32'd0;
    endtask

    task automatic reset_dut(input int fw);
        reset = 1'b1; waitrequest = 1'b0; force_wait = 0;
        repeat (3) @(negedge clk);
        check("rst_read", 32'(read), 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_be", 32'(byteenable), 32'd0);
        check("rst_wdata", writedata, 32'd0);
        reset = 1'b0;
        cyc = 0; stalls = 0; wr_cycles = 0; data_acc = 0;
        force_wait = fw;
        set_wait();
        #1;
        check("post_rst_addr", address, RV);
        check("post_rst_read", 32'(read), 32'd1);
        check("post_rst_be", 32'(byteenable), 32'hF);
        check("post_rst_active", 32'(active), 32'd1);
        check("post_rst_v0", register_v0, 32'd0);
    endtask

    task automatic finish_dut(input int budget);
        while (active && cyc < budget) tick();
        check("halted", 32'(active), 32'd0);
        check("halt_addr", address, 32'd0);
        check("halt_read", 32'(read), 32'd0);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] ea);
        return (ea < 32'd1024) ? ref_mem[ea[9:2]] : 32'd0;
    endfunction

    // Reference model: architectural interpreter with pc/next-pc delay-slot rule.
    task automatic run_model();
        logic [31:0] pc, npc, pc_next, ins, a, b, se, ze, ea, tgt, res, w;
        logic [5:0]  op, fn;
        logic [4:0]  dst;
        logic        tk, wr;
        int          steps, lane;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        pc = RV; npc = RV + 32'd4; m_cycles = 0; steps = 0;
        while (steps < 3000) begin
            ins = (pc - RV < 32'd1024) ? prog_mem[8'((pc - RV) >> 2)] : 32'd0;
            op = ins[31:26]; fn = ins[5:0];
            se = {{16{ins[15]}}, ins[15:0]};
            ze = {16'd0, ins[15:0]};
            a = m_regs[ins[25:21]]; b = m_regs[ins[20:16]];
            ea = a + se; lane = int'(ea[1:0]);
            tk = 1'b0; tgt = 32'd0; wr = 1'b1; dst = ins[20:16]; res = 32'd0;
            m_cycles += 2;
            if (op == 6'h00) begin
                dst = ins[15:11];
                case (fn)
                    6'h00: res = b << ins[10:6];
                    6'h02: res = b >> ins[10:6];
                    6'h03: res = $unsigned($signed(b) >>> ins[10:6]);
                    6'h08: begin wr = 1'b0; tk = 1'b1; tgt = a; end
                    6'h09: begin res = pc + 32'd8; tk = 1'b1; tgt = a; end
                    6'h21: res = a + b;
                    6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
            end else begin
                case (op)
                    6'h02, 6'h03: begin
                        tk = 1'b1;
                        tgt = ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, ins[25:0]} << 2);
                        wr = (op == 6'h03); dst = 5'd31; res = pc + 32'd8;
                    end
                    6'h04: begin wr = 1'b0; tk = (a == b); tgt = pc + 32'd4 + (se << 2); end
                    6'h05: begin wr = 1'b0; tk = (a != b); tgt = pc + 32'd4 + (se << 2); end
                    6'h09: res = a + se;
                    6'h0A: res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
                    6'h0B: res = (a < se) ? 32'd1 : 32'd0;
                    6'h0C: res = a & ze;
                    6'h0D: res = a | ze;
                    6'h0E: res = a ^ ze;
                    6'h0F: res = ze << 16;
                    6'h23: begin m_cycles++; res = ref_load(ea); end
                    6'h2B: begin
                        wr = 1'b0; m_cycles++;
                        if (ea < 32'd1024) ref_mem[ea[9:2]] = b;
                    end
`ifdef MIPS_CPU_BYTE_LS_EN
                    6'h20, 6'h24: begin
                        m_cycles++;
                        w = ref_load(ea) >> (8 * lane);
                        res = (op == 6'h20) ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
                    end
                    6'h28: begin
                        wr = 1'b0; m_cycles++;
                        if (ea < 32'd1024) ref_mem[ea[9:2]][8*lane +: 8] = b[7:0];
                    end
`endif
                    default: wr = 1'b0;
                endcase
            end
            if (wr && dst != 5'd0) m_regs[dst] = res;
            pc_next = npc;
            npc = tk ? tgt : npc + 32'd4;
            pc = pc_next;
            steps++;
            if (pc == 32'd0) break;
        end
    endtask

    task automatic gen_random_prog();
        int n, kind, kmax;
        logic [5:0] op;
        prog_q.delete();
        prog_q.push_back(enc_i(6'h09, 5'd0, 5'd28, 16'h0100));
        for (int r = 1; r < 16; r++) begin
            prog_q.push_back(enc_i(6'h0F, 5'd0, 5'(r), 16'($urandom)));
            prog_q.push_back(enc_i(6'h0D, 5'(r), 5'(r), 16'($urandom)));
        end
        n = $urandom_range(20, 40);
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 9);
            if (kind == 7 && i > n - 3) kind = 0;
            case (kind)
                3, 4: prog_q.push_back(enc_i(i_op[$urandom_range(0, 6)], 5'($urandom_range(0, 15)),
                                             5'($urandom_range(1, 15)), 16'($urandom)));
                5: begin
                    case ($urandom_range(0, 2))
                        0: op = 6'h23;
                        1: op = 6'h20;
                        default: op = 6'h24;
                    endcase
                    prog_q.push_back(enc_i(op, 5'd28, 5'($urandom_range(1, 15)),
                                           16'($urandom_range(0, 63))));
                end
                6: prog_q.push_back(enc_i(($urandom_range(0, 1) == 0) ? 6'h2B : 6'h28, 5'd28,
                                          5'($urandom_range(0, 15)), 16'($urandom_range(0, 63))));
                7: begin
                    kmax = (n - 1 - i < 3) ? n - 1 - i : 3;
                    prog_q.push_back(enc_i(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05,
                                           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                           16'($urandom_range(1, kmax))));
                end
                8: prog_q.push_back(($urandom_range(0, 1) == 0) ? enc_i(6'h3F, 5'd1, 5'd2, 16'h1234)
                                                               : enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F));
                default: prog_q.push_back(enc_r(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                                                5'($urandom_range(1, 15)), 5'($urandom), r_fn[$urandom_range(0, 9)]));
            endcase
        end
        for (int r = 1; r < 16; r++) prog_q.push_back(enc_i(6'h2B, 5'd0, 5'(r), 16'(32'h200 + 4 * r)));
        prog_q.push_back(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        prog_q.push_back(32'd0);
    endtask

    initial begin
        wait_rand = 1'b0; force_wait = 0;
        for (int i = 0; i < 256; i++) begin data_mem[i] = 32'd0; prog_mem[i] = 32'd0; end

        // ADDIU $2,$0,5 ; JR $0 ; NOP
        prog_q.delete();
        prog_q.push_back(enc_i(6'h09, 5'd0, 5'd2, 16'd5));
        prog_q.push_back(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        prog_q.push_back(32'd0);
        load_prog();
        reset_dut(0);
        finish_dut(200);
        check("jr0_v0", register_v0, 32'd5);
        check("jr0_cycles", 32'(cyc), 32'd6);

        // same program with three fetch wait states
        reset_dut(3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr", address, RV);
            check("stall_read", 32'(read), 32'd1);
        end
        finish_dut(200);
        check("stall_v0", register_v0, 32'd5);
        check("stall_cycles", 32'(cyc), 32'd9);

        // reset during a stalled fetch drops the transfer at once
        reset_dut(4);
        tick();
        reset = 1'b1;
        #1;
        check("midrst_read", 32'(read), 32'd0);
        check("midrst_be", 32'(byteenable), 32'd0);

        // LW $2,0($3) from word 0x40
        data_mem[16] = 32'h1234_5678;
        prog_q.delete();
        prog_q.push_back(enc_i(6'h09, 5'd0, 5'd3, 16'h0040));
        prog_q.push_back(enc_i(6'h23, 5'd3, 5'd2, 16'd0));
        prog_q.push_back(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        prog_q.push_back(32'd0);
        load_prog();
        reset_dut(0);
        finish_dut(200);
        check("lw_v0", register_v0, 32'h1234_5678);
        check("lw_be", 32'(last_be), 32'hF);
        check("lw_read", 32'(last_rd), 32'd1);
        check("lw_addr", last_addr, 32'h40);
        check("lw_cycles", 32'(cyc), 32'd9);

        // SW 0xDEADBEEF to 0x10, LW back into $2
        prog_q.delete();
        prog_q.push_back(enc_i(6'h0F, 5'd0, 5'd4, 16'hDEAD));
        prog_q.push_back(enc_i(6'h0D, 5'd4, 5'd4, 16'hBEEF));
        prog_q.push_back(enc_i(6'h2B, 5'd0, 5'd4, 16'h0010));
        prog_q.push_back(enc_i(6'h23, 5'd0, 5'd2, 16'h0010));
        prog_q.push_back(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        prog_q.push_back(32'd0);
        load_prog();
        reset_dut(0);
        finish_dut(200);
        check("sw_v0", register_v0, 32'hDEAD_BEEF);
        check("sw_mem", data_mem[4], 32'hDEAD_BEEF);
        check("sw_write_cycles", 32'(wr_cycles), 32'd1);
        check("sw_cycles", 32'(cyc), 32'd14);

        // BEQ taken: delay-slot increment applies, skipped instruction does not
        prog_q.delete();
        prog_q.push_back(enc_i(6'h09, 5'd0, 5'd2, 16'd10));
        prog_q.push_back(enc_i(6'h04, 5'd0, 5'd0, 16'd2));
        prog_q.push_back(enc_i(6'h09, 5'd2, 5'd2, 16'd1));
        prog_q.push_back(enc_i(6'h09, 5'd2, 5'd2, 16'd100));
        prog_q.push_back(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        prog_q.push_back(32'd0);
        load_prog();
        reset_dut(0);
        finish_dut(200);
        check("beq_v0", register_v0, 32'd11);
        check("beq_cycles", 32'(cyc), 32'd10);

        // JAL links PC+8 into $31
        prog_q.delete();
        prog_q.push_back(enc_j(6'h03, 26'((RV + 32'd12) >> 2)));
        prog_q.push_back(32'd0);
        prog_q.push_back(enc_i(6'h09, 5'd0, 5'd2, 16'd99));
        prog_q.push_back(enc_r(5'd31, 5'd0, 5'd2, 5'd0, 6'h21));
        prog_q.push_back(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
        prog_q.push_back(32'd0);
        load_prog();
        reset_dut(0);
        finish_dut(200);
        check("jal_v0", register_v0, RV + 32'd8);
        check("jal_cycles", 32'(cyc), 32'd10);

        // random programs against the reference interpreter
        for (int t = 0; t < 8; t++) begin
            wait_rand = (t % 2 == 1);
            gen_random_prog();
            load_prog();
            for (int i = 0; i < 256; i++) begin
                data_mem[i] = $urandom;
                ref_mem[i] = data_mem[i];
            end
            run_model();
            for (int r = 1; r < 16; r++) exp_q.push_back(m_regs[r]);
            reset_dut(0);
            finish_dut(4000);
            check("rnd_v0", register_v0, m_regs[2]);
            check("rnd_cycles", 32'(cyc), 32'(m_cycles + stalls));
            for (int i = 0; i < 128; i++) check($sformatf("rnd_mem[%0d]", i), data_mem[i], ref_mem[i]);
            for (int r = 1; r < 16; r++) check($sformatf("rnd_reg%0d", r), data_mem[128 + r], exp_q.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
